// File: rtl/mips_multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller: FSM state
// encoding, opcode/funct field values, ALU operation codes, the internal
// ALUOp code that steers the ALU decoder, and the datapath mux encodings.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int STATE_BITS = 4;

    // Controller states; encodings 12-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SIMM    = 2'b10;
    localparam logic [1:0] SRCB_SIMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the main controller and the multicycle datapath.
//   i_opcode/i_funct  : instruction register fields (stable from DECODE on)
//   i_zero_flag       : ALU zero flag
//   i_mem_ready       : memory completes the current access this cycle
//   o_*               : datapath selects, write enables, ALU op, debug state
// modport master = controller side, modport slave = datapath side.
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [5:0]            i_opcode;
    logic [5:0]            i_funct;
    logic                  i_zero_flag;
    logic                  i_mem_ready;
    logic                  o_mem_req;
    logic                  o_IorD;
    logic                  o_MemWrite;
    logic                  o_IRWrite;
    logic                  o_RegDst;
    logic                  o_MemtoReg;
    logic                  o_RegWrite;
    logic                  o_ALUSrcA;
    logic [1:0]            o_ALUSrcB;
    logic [1:0]            o_PCSrc;
    logic                  o_PCEn;
    logic [2:0]            o_ALUControl;
    logic                  o_illegal_op;
    logic [STATE_BITS-1:0] o_state;

    modport master (
        input  i_opcode, i_funct, i_zero_flag, i_mem_ready,
        output o_mem_req, o_IorD, o_MemWrite, o_IRWrite, o_RegDst, o_MemtoReg,
               o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_PCSrc, o_PCEn,
               o_ALUControl, o_illegal_op, o_state
    );

    modport slave (
        output i_opcode, i_funct, i_zero_flag, i_mem_ready,
        input  o_mem_req, o_IorD, o_MemWrite, o_IRWrite, o_RegDst, o_MemtoReg,
               o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_PCSrc, o_PCEn,
               o_ALUControl, o_illegal_op, o_state
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decoder.
//   i_funct       : R-type funct field
//   i_alu_op      : 00 add, 01 sub, 10 decode from funct
//   o_alu_control : 3-bit ALU operation code
//   o_funct_valid : funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    input  logic [1:0] i_alu_op,
    output logic [2:0] o_alu_control,
    output logic       o_funct_valid
);

    // Supported-funct flag, independent of ALUOp so DECODE can use it
    always_comb begin
        o_funct_valid = 1'b0;
        case (i_funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: o_funct_valid = 1'b1;
            default:                               o_funct_valid = 1'b0;
        endcase
    end

    // ALU operation select
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default:   o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore main controller of the multicycle MIPS core. Walks each instruction
// through fetch/decode/execute/memory/writeback and emits the datapath
// selects, write enables and ALU control for the current state.
//   i_clk   : core clock (rising edge)
//   i_rst_n : asynchronous active-low reset, forces FETCH
//   bus     : controller side of mips_multicycle_ctrl_if (IR fields, zero
//             flag, memory handshake in; datapath controls and state out)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t             state_r;
    state_t             state_nx_s;
    logic [1:0]         alu_op_s;
    logic [2:0]         alu_ctl_s;
    logic               funct_valid_s;
    logic               mem_req_s;
    logic               iord_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               reg_dst_s;
    logic               mem_to_reg_s;
    logic               reg_write_s;
    logic               alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [1:0]         pc_src_s;
    logic               pc_write_s;
    logic               branch_s;
    logic               illegal_s;
    logic [STATE_W-1:0] state_dbg_s;

    alu_decoder u_alu_decoder (
        .i_funct       (bus.i_funct),
        .i_alu_op      (alu_op_s),
        .o_alu_control (alu_ctl_s),
        .o_funct_valid (funct_valid_s)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_nx_s   = S_FETCH;
        mem_req_s    = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_REG;
        pc_src_s     = PCSRC_ALU;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = ALUOP_ADD;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR
                mem_req_s   = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                if (bus.i_mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_nx_s = S_DECODE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b_s = SRCB_SIMM_SH;
                case (bus.i_opcode)
                    OP_LW, OP_SW: state_nx_s = S_MEMADR;
                    OP_BEQ:       state_nx_s = S_BRANCH;
                    OP_ADDI:      state_nx_s = S_ADDIEX;
                    OP_J:         state_nx_s = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_valid_s) begin
                            state_nx_s = S_EXECUTE;
                        end else begin
                            illegal_s  = 1'b1;
                            state_nx_s = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_s  = 1'b1;
                        state_nx_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_SIMM;
                if (bus.i_opcode == OP_LW) begin
                    state_nx_s = S_MEMREAD;
                end else begin
                    state_nx_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (bus.i_mem_ready) begin
                    state_nx_s = S_MEMWB;
                end else begin
                    state_nx_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                state_nx_s   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                if (bus.i_mem_ready) begin
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_MEMWRITE;
                end
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
                state_nx_s  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
                state_nx_s  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_SUB;
                pc_src_s    = PCSRC_ALUOUT;
                branch_s    = 1'b1;
                state_nx_s  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_SIMM;
                state_nx_s  = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                state_nx_s  = S_FETCH;
            end
            S_JUMP: begin
                pc_src_s   = PCSRC_JUMP;
                pc_write_s = 1'b1;
                state_nx_s = S_FETCH;
            end
            default: begin
                state_nx_s = S_FETCH;
            end
        endcase
    end

    // Enables are qualified with reset so nothing is written while it is low;
    // selects need no gating because reset already holds the state at FETCH.
    assign bus.o_mem_req    = mem_req_s & i_rst_n;
    assign bus.o_MemWrite   = mem_write_s & i_rst_n;
    assign bus.o_IRWrite    = ir_write_s & i_rst_n;
    assign bus.o_RegWrite   = reg_write_s & i_rst_n;
    assign bus.o_PCEn       = (pc_write_s | (branch_s & bus.i_zero_flag)) & i_rst_n;
    assign bus.o_illegal_op = illegal_s & i_rst_n;
    assign bus.o_IorD       = iord_s;
    assign bus.o_RegDst     = reg_dst_s;
    assign bus.o_MemtoReg   = mem_to_reg_s;
    assign bus.o_ALUSrcA    = alu_src_a_s;
    assign bus.o_ALUSrcB    = alu_src_b_s;
    assign bus.o_PCSrc      = pc_src_s;
    assign bus.o_ALUControl = alu_ctl_s;
    assign state_dbg_s      = STATE_W'(state_r);
    assign bus.o_state      = state_dbg_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed bench for the multicycle MIPS controller. Each instruction is
// expanded into a per-cycle plan (expected state, memory-ready and zero-flag
// inputs); a compare process checks the outputs of every planned cycle
// against the output table for that state.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         st;
        bit         rdy;
        bit         zero;
        logic [5:0] op;
        logic [5:0] fn;
    } rec_t;

    rec_t plan_q[$];
    rec_t exp_q[$];

    // One comparison; a negative expectation means "don't care"
    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            tests++;
            if (act != exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            end
        end
    endtask

    function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100)
                              || (fn == 6'b100101) || (fn == 6'b101010);
            6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int r_alu(logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic void plan_push(int st, bit rdy, bit zero, logic [5:0] op, logic [5:0] fn);
        rec_t r;
        r.st = st; r.rdy = rdy; r.zero = zero; r.op = op; r.fn = fn;
        plan_q.push_back(r);
    endfunction

    // Instruction -> cycle-by-cycle state walk. fw/mw are memory wait cycles
    // in fetch / data access; idle is the ready level outside those waits.
    function automatic void plan_instr(logic [5:0] op, logic [5:0] fn, bit zero,
                                       int fw, int mw, bit idle);
        plan_q.delete();
        repeat (fw) plan_push(0, 1'b0, zero, op, fn);
        plan_push(0, 1'b1, zero, op, fn);
        plan_push(1, idle, zero, op, fn);
        if (is_legal(op, fn)) begin
            case (op)
                6'b100011: begin
                    plan_push(2, idle, zero, op, fn);
                    repeat (mw) plan_push(3, 1'b0, zero, op, fn);
                    plan_push(3, 1'b1, zero, op, fn);
                    plan_push(4, idle, zero, op, fn);
                end
                6'b101011: begin
                    plan_push(2, idle, zero, op, fn);
                    repeat (mw) plan_push(5, 1'b0, zero, op, fn);
                    plan_push(5, 1'b1, zero, op, fn);
                end
                6'b000000: begin
                    plan_push(6, idle, zero, op, fn);
                    plan_push(7, idle, zero, op, fn);
                end
                6'b000100: plan_push(8, idle, zero, op, fn);
                6'b001000: begin
                    plan_push(9, idle, zero, op, fn);
                    plan_push(10, idle, zero, op, fn);
                end
                default:   plan_push(11, idle, zero, op, fn);
            endcase
        end
    endfunction

    // Drive the first n planned cycles (all if n < 0) just after each rising edge
    task automatic issue(input int n);
        int lim;
        lim = (n < 0) ? plan_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            bus.i_opcode    = plan_q[i].op;
            bus.i_funct     = plan_q[i].fn;
            bus.i_mem_ready = plan_q[i].rdy;
            bus.i_zero_flag = plan_q[i].zero;
            exp_q.push_back(plan_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit zero,
                       input int fw, input int mw, input bit idle);
        plan_instr(op, fn, zero, fw, mw, idle);
        issue(-1);
    endtask

    // Per-cycle output check against the state's output table
    always @(negedge clk) begin : cmp
        rec_t r;
        int e_req, e_iord, e_mw, e_irw, e_rdst, e_m2r, e_rw;
        int e_srca, e_srcb, e_pcsrc, e_pcen, e_ctl, e_ill;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            e_req = 0; e_iord = -1; e_mw = 0; e_irw = 0; e_rdst = -1; e_m2r = -1; e_rw = 0;
            e_srca = -1; e_srcb = -1; e_pcsrc = -1; e_pcen = 0; e_ctl = -1; e_ill = 0;
            case (r.st)
                0: begin
                    e_req = 1; e_iord = 0; e_srca = 0; e_srcb = 1; e_ctl = 2; e_pcsrc = 0;
                    e_irw = int'(r.rdy); e_pcen = int'(r.rdy);
                end
                1:  begin e_srca = 0; e_srcb = 3; e_ctl = 2; e_ill = int'(!is_legal(r.op, r.fn)); end
                2:  begin e_srca = 1; e_srcb = 2; e_ctl = 2; end
                3:  begin e_req = 1; e_iord = 1; end
                4:  begin e_rdst = 0; e_m2r = 1; e_rw = 1; end
                5:  begin e_req = 1; e_iord = 1; e_mw = 1; end
                6:  begin e_srca = 1; e_srcb = 0; e_ctl = r_alu(r.fn); end
                7:  begin e_rdst = 1; e_m2r = 0; e_rw = 1; end
                8:  begin e_srca = 1; e_srcb = 0; e_ctl = 6; e_pcsrc = 1; e_pcen = int'(r.zero); end
                9:  begin e_srca = 1; e_srcb = 2; e_ctl = 2; end
                10: begin e_rdst = 0; e_m2r = 0; e_rw = 1; end
                11: begin e_pcsrc = 2; e_pcen = 1; end
                default: ;
            endcase
            chk("state",      int'(bus.o_state),      r.st);
            chk("mem_req",    int'(bus.o_mem_req),    e_req);
            chk("IorD",       int'(bus.o_IorD),       e_iord);
            chk("MemWrite",   int'(bus.o_MemWrite),   e_mw);
            chk("IRWrite",    int'(bus.o_IRWrite),    e_irw);
            chk("RegDst",     int'(bus.o_RegDst),     e_rdst);
            chk("MemtoReg",   int'(bus.o_MemtoReg),   e_m2r);
            chk("RegWrite",   int'(bus.o_RegWrite),   e_rw);
            chk("ALUSrcA",    int'(bus.o_ALUSrcA),    e_srca);
            chk("ALUSrcB",    int'(bus.o_ALUSrcB),    e_srcb);
            chk("PCSrc",      int'(bus.o_PCSrc),      e_pcsrc);
            chk("PCEn",       int'(bus.o_PCEn),       e_pcen);
            chk("ALUControl", int'(bus.o_ALUControl), e_ctl);
            chk("illegal_op", int'(bus.o_illegal_op), e_ill);
            chk("one_write",  int'(bus.o_RegWrite) + int'(bus.o_MemWrite) + int'(bus.o_IRWrite) > 1 ? 1 : 0, 0);
        end
    end

    int lw_seq[8] = '{0, 1, 2, 3, 3, 3, 3, 4};

    initial begin
        rst_n           = 1'b0;
        bus.i_opcode    = 6'b000000;
        bus.i_funct     = 6'b000000;
        bus.i_zero_flag = 1'b0;
        bus.i_mem_ready = 1'b1;

        // Reset state: FETCH, enables low even with memory ready
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   int'(bus.o_state),   0);
        chk("rst_mem_req", int'(bus.o_mem_req), 0);
        chk("rst_IRWrite", int'(bus.o_IRWrite), 0);
        chk("rst_PCEn",    int'(bus.o_PCEn),    0);
        chk("rst_ALUSrcB", int'(bus.o_ALUSrcB), 1);
        rst_n = 1'b1;
        #1;
        chk("rel_mem_req", int'(bus.o_mem_req), 1);

        // add, memory always ready
        plan_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b1);
        chk("model_add_len", plan_q.size(), 4);
        issue(-1);

        // lw with three wait cycles in MEMREAD
        plan_instr(6'b100011, 6'b010101, 1'b0, 0, 3, 1'b0);
        chk("model_lw_len", plan_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("model_lw_seq", plan_q[i].st, lw_seq[i]);
        issue(-1);

        // beq taken, then not taken after a 2-cycle fetch wait
        plan_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
        chk("model_beq_len", plan_q.size(), 3);
        issue(-1);
        run(6'b000100, 6'b000000, 1'b0, 2, 0, 1'b1);

        // illegal opcode, illegal R-type funct
        plan_instr(6'b111111, 6'b100000, 1'b0, 0, 0, 1'b1);
        chk("model_ill_len", plan_q.size(), 2);
        issue(-1);
        run(6'b000000, 6'b000111, 1'b0, 0, 0, 1'b0);

        // sw then j, memory always ready
        plan_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b1);
        chk("model_sw_len", plan_q.size(), 4);
        issue(-1);
        plan_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b1);
        chk("model_j_len", plan_q.size(), 3);
        issue(-1);

        // remaining R-type ops, addi, zero-wait lw, sw with waits
        run(6'b000000, 6'b100010, 1'b1, 0, 0, 1'b0);
        run(6'b000000, 6'b100100, 1'b0, 1, 0, 1'b1);
        run(6'b000000, 6'b100101, 1'b0, 0, 0, 1'b0);
        run(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b1);
        plan_instr(6'b001000, 6'b111111, 1'b0, 1, 0, 1'b0);
        chk("model_addi_len", plan_q.size(), 5);
        issue(-1);
        run(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b1);
        run(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b0);

        // Reset asserted while lw waits in MEMREAD
        plan_instr(6'b100011, 6'b000000, 1'b0, 0, 5, 1'b0);
        issue(5);
        chk("pre_rst_state", int'(bus.o_state), 3);
        bus.i_mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state",    int'(bus.o_state),    0);
        chk("arst_RegWrite", int'(bus.o_RegWrite), 0);
        chk("arst_MemWrite", int'(bus.o_MemWrite), 0);
        chk("arst_mem_req",  int'(bus.o_mem_req),  0);
        chk("arst_IRWrite",  int'(bus.o_IRWrite),  0);
        chk("arst_PCEn",     int'(bus.o_PCEn),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arel_state",   int'(bus.o_state),   0);
        chk("arel_mem_req", int'(bus.o_mem_req), 1);
        run(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);

        @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
